troco_dispenser: RTL and testbench

//   Downstream stage of the drink vending FSM: pays out the change it computes.
//   On the machine's devolve strobe it latches troco (count of R$0,50 coins).
//   It then fires the coin-ejector solenoid once per coin and waits for the

---
 rtl/troco_dispenser_pkg.sv | 23 ++
 rtl/troco_dispenser_timer.sv | 29 ++
 rtl/troco_dispenser.sv | 142 ++++++++++++++
 tb/tb_troco_dispenser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/troco_dispenser_pkg.sv
// Shared definitions for the change dispenser: state encoding, default
// coin-count width and the timer sizing helper.
package troco_dispenser_pkg;

  // Same width as the vending FSM troco[3:0] bus
  localparam int TROCO_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EJECT    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_JAM      = 3'd4
  } state_t;

  // The timer is loaded with (cycles - 1), so clog2 of the larger interval is enough
  function automatic int timer_width(input int pulse_cycles, input int timeout);
    int m;
    m = (pulse_cycles > timeout) ? pulse_cycles : timeout;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/troco_dispenser_timer.sv
// Loadable down-counter with a zero flag; shared between the solenoid pulse
// width and the drop-sensor timeout.
module troco_dispenser_timer #(
  parameter int W_T = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W_T-1:0] load_val,
  input  logic           dec,
  output logic           zero
);

  logic [W_T-1:0] cnt;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W_T'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/troco_dispenser.sv
// Change dispenser: latches the coin count on devolve, fires the ejector once
// per coin, waits for the drop sensor and flags a sticky jam on timeout.
module troco_dispenser
  import troco_dispenser_pkg::*;
#(
  parameter int W            = TROCO_W_DEFAULT,
  parameter int PULSE_CYCLES = 2,
  parameter int TIMEOUT      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         devolve,
  input  logic [W-1:0] troco,
  input  logic         coin_ack,
  output logic         coin_out,
  output logic [W-1:0] pendente,
  output logic         busy,
  output logic         done,
  output logic         erro
);

  localparam int             W_T          = timer_width(PULSE_CYCLES, TIMEOUT);
  localparam logic [W_T-1:0] PULSE_LOAD   = W_T'(PULSE_CYCLES - 1);
  localparam logic [W_T-1:0] TIMEOUT_LOAD = W_T'(TIMEOUT - 1);
  localparam logic [W-1:0]   ONE          = W'(1);

  state_t         state;
  logic           tmr_load;
  logic [W_T-1:0] tmr_val;
  logic           tmr_dec;
  logic           tmr_zero;

  troco_dispenser_timer #(
    .W_T (W_T)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Timer control: reload on every entry to EJECT or WAIT_ACK, otherwise count down
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LOAD;
    tmr_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_load = devolve && (troco != '0);
      end
      ST_EJECT: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (coin_ack) begin
          tmr_load = (pendente > ONE);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Payout FSM with registered outputs and the pendente register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pendente <= '0;
      coin_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      erro     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (devolve) begin
            pendente <= troco;
            busy     <= 1'b1;
            if (troco != '0) begin
              state    <= ST_EJECT;
              coin_out <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_EJECT: begin
          if (tmr_zero) begin
            state    <= ST_WAIT_ACK;
            coin_out <= 1'b0;
          end
        end
        ST_WAIT_ACK: begin
          // An ack arriving on the last timeout cycle still counts
          if (coin_ack) begin
            if (pendente != '0) begin
              pendente <= pendente - ONE;
            end
            if (pendente <= ONE) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_EJECT;
              coin_out <= 1'b1;
            end
          end else if (tmr_zero) begin
            state <= ST_JAM;
            busy  <= 1'b0;
            erro  <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          pendente <= '0;
          busy     <= 1'b0;
        end
        ST_JAM: begin
          // Unpaid count stays visible; only rst leaves this state
          state    <= ST_JAM;
          coin_out <= 1'b0;
          erro     <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          coin_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_troco_dispenser.sv
// Bench for troco_dispenser: randomized payouts checked cycle by cycle
// against an expected timeline built from pulse/wait/ack rules.
module tb_troco_dispenser;

  localparam int W    = 4;
  localparam int P    = 2;
  localparam int T    = 8;
  localparam int MAXC = 400;

  logic         clk = 1'b0;
  logic         rst;
  logic         devolve;
  logic [W-1:0] troco;
  logic         coin_ack;
  logic         coin_out;
  logic [W-1:0] pendente;
  logic         busy;
  logic         done;
  logic         erro;

  always #5 clk = ~clk;

  troco_dispenser #(
    .W            (W),
    .PULSE_CYCLES (P),
    .TIMEOUT      (T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .devolve  (devolve),
    .troco    (troco),
    .coin_ack (coin_ack),
    .coin_out (coin_out),
    .pendente (pendente),
    .busy     (busy),
    .done     (done),
    .erro     (erro)
  );

  int total = 0;
  int bad   = 0;

  // Expected outputs after edge j, where edge 0 samples devolve
  int e_coin [MAXC];
  int e_pend [MAXC];
  int e_busy [MAXC];
  int e_done [MAXC];
  int e_err  [MAXC];
  int ack_at [MAXC];
  int len;
  int first_ack;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int j);
    chk($sformatf("%s[%0d].coin_out", tag, j), {7'd0, coin_out}, 8'(e_coin[j]));
    chk($sformatf("%s[%0d].pendente", tag, j), {4'd0, pendente}, 8'(e_pend[j]));
    chk($sformatf("%s[%0d].busy", tag, j), {7'd0, busy}, 8'(e_busy[j]));
    chk($sformatf("%s[%0d].done", tag, j), {7'd0, done}, 8'(e_done[j]));
    chk($sformatf("%s[%0d].erro", tag, j), {7'd0, erro}, 8'(e_err[j]));
  endtask

  // Timeline: each coin = P pulse cycles, then d wait cycles, ack sampled at the
  // next edge which also starts the next pulse. A jammed coin waits T cycles.
  task automatic build(input int n, input int jam_coin, input int fixed_d);
    int s;
    int d;
    for (int j = 0; j < MAXC; j++) begin
      e_coin[j] = 0; e_pend[j] = 0; e_busy[j] = 0;
      e_done[j] = 0; e_err[j] = 0; ack_at[j] = 0;
    end
    first_ack = -1;
    s = 0;
    if (n == 0) begin
      e_busy[0] = 1;
      e_done[0] = 1;
      len = 4;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int j = s; j < s + P; j++) begin
        e_coin[j] = 1; e_busy[j] = 1; e_pend[j] = n - i;
      end
      if (i == jam_coin) begin
        for (int j = s + P; j < s + P + T; j++) begin
          e_busy[j] = 1; e_pend[j] = n - i;
        end
        for (int j = s + P + T; j < MAXC; j++) begin
          e_err[j] = 1; e_pend[j] = n - i;
        end
        len = s + P + T + 5;
        return;
      end
      d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, T));
      for (int j = s + P; j < s + P + d; j++) begin
        e_busy[j] = 1; e_pend[j] = n - i;
      end
      s = s + P + d;
      ack_at[s] = 1;
      if (first_ack < 0) first_ack = s;
    end
    e_done[s] = 1;
    e_busy[s] = 1;
    e_pend[s] = 0;
    len = s + 4;
  endtask

  // A reset sampled at edge a returns everything to zero from that edge on
  task automatic apply_abort(input int a);
    for (int j = a; j < MAXC; j++) begin
      e_coin[j] = 0; e_pend[j] = 0; e_busy[j] = 0;
      e_done[j] = 0; e_err[j] = 0; ack_at[j] = 0;
    end
    len = a + 4;
  endtask

  task automatic run(input string tag, input int n, input bit strays, input int abort_at);
    @(negedge clk);
    devolve = 1'b1;
    troco   = W'(n);
    for (int j = 0; j < len; j++) begin
      @(posedge clk);
      #1;
      devolve  = 1'b0;
      coin_ack = 1'b0;
      rst      = 1'b0;
      if (ack_at[j + 1] != 0) begin
        coin_ack = 1'b1;
      end else if (strays && e_coin[j] != 0 && $urandom_range(0, 2) == 0) begin
        coin_ack = 1'b1;
      end
      if (strays && (e_busy[j] != 0 || e_err[j] != 0) && $urandom_range(0, 1) == 1) begin
        devolve = 1'b1;
        troco   = W'($urandom);
      end
      if (abort_at == j + 1) rst = 1'b1;
      @(negedge clk);
      chk_all(tag, j);
    end
    devolve  = 1'b0;
    coin_ack = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst     = 1'b1;
    devolve = 1'b1;
    troco   = 4'd7;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst     = 1'b0;
    devolve = 1'b0;
    chk({tag, ".coin_out"}, {7'd0, coin_out}, 8'd0);
    chk({tag, ".pendente"}, {4'd0, pendente}, 8'd0);
    chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
    chk({tag, ".done"}, {7'd0, done}, 8'd0);
    chk({tag, ".erro"}, {7'd0, erro}, 8'd0);
  endtask

  initial begin
    int n;
    // Reset held two cycles with devolve asserted: nothing may start
    rst      = 1'b1;
    devolve  = 1'b1;
    troco    = 4'd5;
    coin_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("reset%0d.coin_out", k), {7'd0, coin_out}, 8'd0);
      chk($sformatf("reset%0d.pendente", k), {4'd0, pendente}, 8'd0);
      chk($sformatf("reset%0d.busy", k), {7'd0, busy}, 8'd0);
      chk($sformatf("reset%0d.done", k), {7'd0, done}, 8'd0);
      chk($sformatf("reset%0d.erro", k), {7'd0, erro}, 8'd0);
    end
    rst     = 1'b0;
    devolve = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset.busy", {7'd0, busy}, 8'd0);
    chk("post_reset.pendente", {4'd0, pendente}, 8'd0);

    // Three coins, each acked on the first wait cycle: done 9 edges after devolve
    build(3, -1, 1);
    chk("troco3.done_edge", 8'(first_ack), 8'(P + 1));
    run("troco3", 3, 1'b0, -1);

    // Zero change: immediate done, no ejection
    build(0, -1, 0);
    run("troco0", 0, 1'b0, -1);

    // Random payouts with random ack delays, stray acks and stray devolves
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      build(n, -1, 0);
      run($sformatf("rand%0d", r), n, 1'b1, -1);
    end

    // Full-scale request pays 15 coins
    build(15, -1, 0);
    run("troco15", 15, 1'b1, -1);

    // Jam on the first coin of two; further devolves ignored; rst clears erro
    build(2, 0, 0);
    run("jam2", 2, 1'b1, -1);
    do_reset("jam2_clear");

    // Jam on a random coin of a random request
    n = $urandom_range(2, 7);
    build(n, $urandom_range(1, n - 1), 0);
    run("jam_rand", n, 1'b1, -1);
    do_reset("jam_rand_clear");

    // Reset right after the first confirmed coin of four drops the rest
    build(4, -1, 0);
    apply_abort(first_ack + 1);
    run("abort4", 4, 1'b0, first_ack + 1);

    // Deepest ack (last timeout cycle) still counts
    build(2, -1, T);
    run("late_ack", 2, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
